// File: rtl/preparacao_sweep_checker_pkg.sv
// Shared types and constants for the preparacao sweep checker.
package preparacao_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_t;

  localparam int VEC_W = 4;
  localparam int RES_W = 6;
  localparam logic [VEC_W-1:0] LAST_VEC = 4'd15;

  // bit 5 = a ... bit 0 = f
  localparam logic [RES_W-1:0] GRP_X_MASK = 6'b101010;
  localparam logic [RES_W-1:0] GRP_Y_MASK = 6'b010101;

  // A group agrees when its masked bits are all zero or all one.
  function automatic logic grp_uniform(input logic [RES_W-1:0] res,
                                       input logic [RES_W-1:0] mask);
    return ((res & mask) == '0) || ((res & mask) == mask);
  endfunction

endpackage

// File: rtl/preparacao_grp_cmp.sv
// Flags a result word whose X (a,c,e) or Y (b,d,f) implementations disagree.
module preparacao_grp_cmp
  import preparacao_pkg::*;
(
  input  logic [RES_W-1:0] res_i,
  output logic             mismatch
);

  assign mismatch = !grp_uniform(res_i, GRP_X_MASK) || !grp_uniform(res_i, GRP_Y_MASK);

endmodule

// File: rtl/preparacao_sweep_checker.sv
// Sweeps all 16 {A,B,C,D} vectors through preparacao and counts group disagreements.
// Define PREPARACAO_FIRST_FAIL_CAPTURE_EN to latch the first failing vector/result.
module preparacao_sweep_checker
  import preparacao_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [VEC_W-1:0] vec_o,
  input  logic [RES_W-1:0] res_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       mismatch_cnt,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec,
  output logic [RES_W-1:0] fail_res
);

  localparam logic [3:0]   SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  // Entry state for every vector: zero settle time skips SETTLE entirely.
  localparam sweep_state_t VEC_ENTRY   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  sweep_state_t state, state_nxt;
  logic [3:0]   settle_cnt;
  logic         mismatch;
  logic         launch;

  preparacao_grp_cmp u_grp_cmp (
    .res_i    (res_i),
    .mismatch (mismatch)
  );

  assign launch = start && (state == IDLE || state == DONE);
  assign busy   = (state == SETTLE) || (state == SAMPLE);
  assign done   = (state == DONE);
  assign pass   = done && (mismatch_cnt == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = VEC_ENTRY;
      SETTLE:     if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (vec_o == LAST_VEC) ? DONE : VEC_ENTRY;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_o        <= '0;
      mismatch_cnt <= '0;
      settle_cnt   <= '0;
    end else if (launch) begin
      vec_o        <= '0;
      mismatch_cnt <= '0;
      settle_cnt   <= '0;
    end else begin
      case (state)
        SETTLE: settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
        SAMPLE: begin
          if (mismatch) mismatch_cnt <= mismatch_cnt + 5'd1;
          // vec_o parks at the last vector; only a new start rewinds it.
          if (vec_o != LAST_VEC) vec_o <= vec_o + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef PREPARACAO_FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_res   <= '0;
    end else if (launch) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_res   <= '0;
    end else if (state == SAMPLE && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= vec_o;
      fail_res   <= res_i;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = '0;
  assign fail_res   = '0;
`endif

endmodule

// File: tb/tb_preparacao_sweep_checker.sv
// Directed bench: two checkers (SETTLE_CYCLES=1 and 0) driven by behavioural preparacao models.
module tb_preparacao_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  int         mode1 = 0, mode0 = 0;  // 0 clean, 1 e-fault on {3,9,12}, 2 every vector fails

  logic [3:0] vec1, vec0;
  logic [5:0] res1, res0;
  logic       busy1, done1, pass1, fv1, busy0, done0, pass0, fv0;
  logic [4:0] cnt1, cnt0;
  logic [3:0] fvec1, fvec0;
  logic [5:0] fres1, fres0;

  int n_chk = 0, n_pass = 0;
  int done_cyc1, done_cyc0, busy_cnt0;

  always #5 clk = ~clk;

  function automatic logic [5:0] model(input int m, input logic [3:0] v);
    logic [5:0] r;
    r = {6{v[0]}};
    if (m == 1 && (v == 4'd3 || v == 4'd9 || v == 4'd12)) r[1] = ~r[1];
    if (m == 2) r[5] = ~r[5];
    return r;
  endfunction

  assign res1 = model(mode1, vec1);
  assign res0 = model(mode0, vec0);

  preparacao_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec1), .res_i(res1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1),
    .fail_valid(fv1), .fail_vec(fvec1), .fail_res(fres1));

  preparacao_sweep_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec0), .res_i(res0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(cnt0),
    .fail_valid(fv0), .fail_vec(fvec0), .fail_res(fres0));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_vec1"}, 32'(vec1), 0);  chk({pfx, "_vec0"}, 32'(vec0), 0);
    chk({pfx, "_busy1"}, 32'(busy1), 0); chk({pfx, "_busy0"}, 32'(busy0), 0);
    chk({pfx, "_done1"}, 32'(done1), 0); chk({pfx, "_done0"}, 32'(done0), 0);
    chk({pfx, "_pass1"}, 32'(pass1), 0); chk({pfx, "_cnt1"}, 32'(cnt1), 0);
    chk({pfx, "_cnt0"}, 32'(cnt0), 0);   chk({pfx, "_fv1"}, 32'(fv1), 0);
    chk({pfx, "_fvec1"}, 32'(fvec1), 0); chk({pfx, "_fres1"}, 32'(fres1), 0);
  endtask

  // Start at edge 0 (cycle 0); done cycle = edges since start + 1. Optional stray starts at edges 5 and 10.
  task automatic run_sweep(input bit stray);
    int e;
    done_cyc1 = -1; done_cyc0 = -1; busy_cnt0 = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("launch_busy1", 32'(busy1), 1); chk("launch_vec1", 32'(vec1), 0);
    chk("launch_busy0", 32'(busy0), 1); chk("launch_vec0", 32'(vec0), 0);
    e = 0;
    while (e <= 60 && (done_cyc1 < 0 || done_cyc0 < 0)) begin
      if (busy0) busy_cnt0++;
      if (done1 && done_cyc1 < 0) done_cyc1 = e + 1;
      if (done0 && done_cyc0 < 0) done_cyc0 = e + 1;
      start = stray && (e == 4 || e == 9);
      e++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_cyc1", 32'(done_cyc1), 33);
    chk("done_cyc0", 32'(done_cyc0), 17);
    chk("busy_cnt0", 32'(busy_cnt0), 16);
  endtask

  initial begin
    #2;
    chk_reset("rst");
    #20 rst_n = 1'b1;

    // Clean model on dut1, all-fail model on dut0, stray starts ignored.
    mode1 = 0; mode0 = 2;
    run_sweep(1'b1);
    chk("clean_cnt1", 32'(cnt1), 0);   chk("clean_pass1", 32'(pass1), 1);
    chk("clean_fv1", 32'(fv1), 0);     chk("clean_vec1", 32'(vec1), 15);
    chk("clean_busy1", 32'(busy1), 0);
    chk("all_cnt0", 32'(cnt0), 16);    chk("all_pass0", 32'(pass0), 0);
    chk("all_vec0", 32'(vec0), 15);
`ifdef PREPARACAO_FIRST_FAIL_CAPTURE_EN
    chk("all_fv0", 32'(fv0), 1); chk("all_fvec0", 32'(fvec0), 0); chk("all_fres0", 32'(fres0), 32'h20);
`else
    chk("all_fv0", 32'(fv0), 0); chk("all_fvec0", 32'(fvec0), 0); chk("all_fres0", 32'(fres0), 0);
`endif
    repeat (3) @(negedge clk);
    chk("hold_done1", 32'(done1), 1);  chk("hold_cnt0", 32'(cnt0), 16);

    // Restart from DONE: fault on dut1, clean on dut0 (clears previous capture/count).
    mode1 = 1; mode0 = 0;
    run_sweep(1'b0);
    chk("flt_cnt1", 32'(cnt1), 3);     chk("flt_pass1", 32'(pass1), 0);
    chk("re_cnt0", 32'(cnt0), 0);      chk("re_pass0", 32'(pass0), 1);
    chk("re_fv0", 32'(fv0), 0);        chk("re_fres0", 32'(fres0), 0);
`ifdef PREPARACAO_FIRST_FAIL_CAPTURE_EN
    chk("flt_fv1", 32'(fv1), 1); chk("flt_fvec1", 32'(fvec1), 3); chk("flt_fres1", 32'(fres1), 32'h3D);
`else
    chk("flt_fv1", 32'(fv1), 0); chk("flt_fvec1", 32'(fvec1), 0); chk("flt_fres1", 32'(fres1), 0);
`endif

    // Reset mid-sweep once dut1 reaches vector 7 (vector 3 already counted).
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    begin
      int w;
      w = 0;
      while (vec1 != 4'd7 && w < 40) begin @(negedge clk); w++; end
      chk("reach_vec7", 32'(vec1), 7);
    end
    chk("mid_cnt1", 32'(cnt1), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk) rst_n = 1'b1;

    mode1 = 0; mode0 = 0;
    run_sweep(1'b0);
    chk("post_cnt1", 32'(cnt1), 0);    chk("post_pass1", 32'(pass1), 1);
    chk("post_vec1", 32'(vec1), 15);   chk("post_pass0", 32'(pass0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
